// File: rtl/velocity_stream_pkg.sv
// Shared types for the velocity cell streamer.
// FSM states and {vz,vy,vx} field slice positions.
package velocity_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FIN
  } state_e;

  localparam int FIELD_W = 32;
  localparam int VX_LSB  = 0;
  localparam int VY_LSB  = 32;
  localparam int VZ_LSB  = 64;

endpackage

// File: rtl/vel_stream_fifo.sv
// Synchronous FIFO buffering tagged read data for the stream output.
// Ports: push/push_data in, pop/pop_data out, count = occupancy.
module vel_stream_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = bump(wr_ptr_q);
    if (pop)  rd_ptr_d = bump(rd_ptr_q);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/velocity_cell_streamer.sv
// Reads a cell's particle count, streams its velocities out over
// valid/ready, and shares the RAM port with write-back traffic.
module velocity_cell_streamer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  import velocity_stream_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT =
    ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] tag_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] tag_d [RD_LATENCY];

  logic                  issue;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic                  ret_valid;
  logic [ADDR_WIDTH-1:0] ret_tag;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic                  push;
  logic                  pop;
  logic [FW-1:0]         fifo_out;
  logic [CW-1:0]         fifo_count;

  assign ret_valid = vld_q[RD_LATENCY-1];
  assign ret_tag   = tag_q[RD_LATENCY-1];
  assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Each in-flight read has a FIFO slot reserved, so pushes never
  // overflow even when the consumer stalls.
  always_comb begin
    issue = 1'b0;
    if ((state_q == RD_CNT || state_q == STREAM) && !wb_valid)
      issue = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_L;
  end

  assign iss_addr = (state_q == RD_CNT) ? '0 : rd_addr_q;
  assign push = ret_valid &&
                (state_q == STREAM || state_q == DRAIN);

  always_comb begin
    vld_d[0] = issue;
    tag_d[0] = iss_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    inflight_d = inflight_q + CW'(issue) - CW'(ret_valid);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_CNT;
          err_d   = 1'b0;
        end
      end
      RD_CNT: begin
        if (issue) state_d = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (ret_valid) begin
          rd_addr_d = ADDR_WIDTH'(1);
          if (cnt_raw > MAX_CNT) begin
            cnt_d = MAX_CNT;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_raw;
          end
          state_d = (cnt_raw == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          if (rd_addr_q == cnt_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the last pop so done lands the cycle after it.
        if (inflight_q == '0 &&
            (fifo_count == '0 ||
             (fifo_count == CW'(1) && pop)))
          state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
      vld_q      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
    end
  end

  vel_stream_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({ret_tag, mem_q}),
    .pop      (pop),
    .pop_data (fifo_out),
    .count    (fifo_count)
  );

  always_comb begin
    mem_rden    = issue;
    mem_wren    = wb_valid;
    mem_address = '0;
    mem_data    = '0;
    unique case (1'b1)
      wb_valid: begin
        mem_address = wb_addr;
        mem_data    = wb_data;
      end
      issue:   mem_address = iss_addr;
      default: mem_address = '0;
    endcase
  end

  assign out_data  = out_valid ? fifo_out[DATA_WIDTH-1:0] : '0;
  assign out_index = out_valid ? fifo_out[FW-1:DATA_WIDTH] : '0;

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign count_err      = err_q;
  assign particle_count = cnt_q;

endmodule

// File: tb/tb_velocity_cell_streamer.sv
// Scoreboard bench for velocity_cell_streamer with a 1-cycle RAM.
// Directed count/backpressure/write-back/clamp/reset scenarios.
module tb_velocity_cell_streamer;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          count_err;
  logic [AW-1:0] particle_count;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  velocity_cell_streamer #(
    .DATA_WIDTH(DW),
    .PARTICLE_NUM(PN),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .count_err(count_err),
    .particle_count(particle_count),
    .mem_address(mem_address),
    .mem_rden(mem_rden),
    .mem_wren(mem_wren),
    .mem_data(mem_data),
    .mem_q(mem_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    int            rel;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ram [PN];
  int            checks;
  int            failures;
  int            cyc;
  int            s0;
  int            npop;
  int            pend;
  bit            busy_log [1:16];
  bit            busy_after;

  localparam logic [DW-1:0] VA = 96'h3f800000_40000000_40400000;
  localparam logic [DW-1:0] VB = 96'hbf800000_c0000000_c0400000;
  localparam logic [DW-1:0] VC = 96'h41200000_41a00000_41f00000;
  localparam logic [DW-1:0] VW = 96'hdeadbeef_cafef00d_12345678;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_address];
  end

  function automatic logic [DW-1:0] pat(input int i);
    return {32'h40000000 + 32'(i), 32'h50000000 + 32'(i),
            32'h60000000 + 32'(i)};
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: scoreboard pops and read-issue credit check.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (mem_rden && mem_address != '0) begin
          check("rd_credit", 128'(pend < 4), 128'd1);
          pend++;
        end
        if (out_valid && out_ready) begin
          pend--;
          npop++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0d required=none",
                     out_index);
          end else begin
            e = exp_q.pop_front();
            check("out_index", 128'(out_index), 128'(e.idx));
            check("out_data", 128'(out_data), 128'(e.data));
            if (e.rel > 0)
              check("out_cycle", 128'(cyc - s0 + 1), 128'(e.rel));
          end
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [DW-1:0] d,
                          input int rel);
    exp_t e;
    e.idx  = AW'(i);
    e.data = d;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic run(input bit tog, input int wb_at, output int dc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s0 = cyc;
    dc = -1;
    for (int k = 1; k <= 600 && dc < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (tog) out_ready = (k % 4 == 1) || (k % 4 == 0);
      if (wb_at > 0 && k >= wb_at && k < wb_at + 3) begin
        wb_valid = 1'b1;
        wb_addr  = AW'(50);
        wb_data  = VW;
      end else if (wb_at > 0 && k == wb_at + 3) begin
        wb_valid = 1'b0;
      end
      #1;
      if (k <= 16) busy_log[k] = busy;
      if (wb_at > 0 && k >= wb_at && k < wb_at + 3) begin
        check("wb_wren", 128'(mem_wren), 128'd1);
        check("wb_rden", 128'(mem_rden), 128'd0);
        check("wb_addr", 128'(mem_address), 128'd50);
      end
      if (wb_at > 0 && k == wb_at + 3) begin
        check("resume_rden", 128'(mem_rden), 128'd1);
        check("resume_addr", 128'(mem_address), 128'd3);
      end
      if (done) dc = k;
    end
    out_ready = 1'b1;
    if (dc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
    @(negedge clk);
    #1;
    busy_after = busy;
  endtask

  initial begin
    int dc;
    int base;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    npop     = 0;
    pend     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    out_ready = 1'b1;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_rden", 128'(mem_rden), 128'd0);
    check("rst_pcount", 128'(particle_count), 128'd0);
    check("rst_err", 128'(count_err), 128'd0);

    // Count 3: A,B,C at cycles 5..7, done at 8.
    wr(0, 96'd3);
    wr(1, VA);
    wr(2, VB);
    wr(3, VC);
    push_exp(1, VA, 5);
    push_exp(2, VB, 6);
    push_exp(3, VC, 7);
    run(1'b0, 0, dc);
    check("t1_done_cyc", 128'(dc), 128'd8);
    check("t1_busy_after", 128'(busy_after), 128'd0);
    check("t1_pcount", 128'(particle_count), 128'd3);
    check("t1_err", 128'(count_err), 128'd0);
    check("t1_drained", 128'(exp_q.size()), 128'd0);

    // Count 0: done in cycle 3, busy cycles 1..3.
    wr(0, 96'd0);
    run(1'b0, 0, dc);
    check("t2_done_cyc", 128'(dc), 128'd3);
    check("t2_busy1", 128'(busy_log[1]), 128'd1);
    check("t2_busy3", 128'(busy_log[3]), 128'd1);
    check("t2_busy_after", 128'(busy_after), 128'd0);

    // Count 10 with out_ready toggling 1-0-0-1.
    wr(0, 96'd10);
    for (int i = 1; i <= 10; i++) wr(AW'(i), pat(i));
    for (int i = 1; i <= 10; i++) push_exp(i, pat(i), -1);
    run(1'b1, 0, dc);
    check("t3_pcount", 128'(particle_count), 128'd10);
    check("t3_drained", 128'(exp_q.size()), 128'd0);

    // Count 8 with a 3-cycle write-back burst at address 50.
    wr(0, 96'd8);
    for (int i = 1; i <= 8; i++) push_exp(i, pat(i), -1);
    run(1'b0, 5, dc);
    check("t4_drained", 128'(exp_q.size()), 128'd0);
    check("t4_ram50", 128'(ram[50]), 128'(VW));

    // Count 255 clamps to 219 with count_err.
    wr(0, 96'd255);
    for (int i = 1; i <= 219; i++) wr(AW'(i), pat(i));
    for (int i = 1; i <= 219; i++) push_exp(i, pat(i), -1);
    run(1'b0, 0, dc);
    check("t5_pcount", 128'(particle_count), 128'd219);
    check("t5_err", 128'(count_err), 128'd1);
    check("t5_drained", 128'(exp_q.size()), 128'd0);

    // Reset after the second output, then a fresh stream.
    wr(0, 96'd5);
    for (int i = 1; i <= 5; i++) push_exp(i, pat(i), -1);
    base = npop;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s0 = cyc;
    for (int k = 0; k < 40 && npop < base + 2; k++) begin
      @(negedge clk);
      #3;
    end
    check("t6_two_pops", 128'(npop - base), 128'd2);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 128'(out_valid), 128'd0);
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_done", 128'(done), 128'd0);
    check("t6_rden", 128'(mem_rden), 128'd0);
    check("t6_addr", 128'(mem_address), 128'd0);
    check("t6_data", 128'(out_data), 128'd0);
    check("t6_pcount", 128'(particle_count), 128'd0);
    check("t6_err", 128'(count_err), 128'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_no_done", 128'(done), 128'd0);
    wr(0, 96'd2);
    push_exp(1, pat(1), 5);
    push_exp(2, pat(2), 6);
    run(1'b0, 0, dc);
    check("t6_done_cyc", 128'(dc), 128'd7);
    check("t6_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
